// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the ARM-subset processor: main FSM, ALU decoder,
// condition check and the architectural NZCV flag register.
module multicycle_ctrl #(
    parameter int         EXT_OPS   = 1,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] Flags
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_EOR = 3'b100,
        ALU_MOV = 3'b101
    } alu_t;

    state_t state;
    alu_t   alu_op;
    logic   no_write;
    logic   set_flags;
    logic   write_cv;
    logic   cond_ex;
    logic   pc_w, reg_w, mem_w, ir_w;
    logic   rd_pc;

    assign rd_pc = (Rd == 4'd15);

    // ALU decode; an unimplemented cmd becomes an ADD with no write and no flags
    always_comb begin
        logic implemented;
        logic forced_s;
        alu_op      = ALU_ADD;
        no_write    = 1'b0;
        implemented = 1'b1;
        forced_s    = 1'b0;
        write_cv    = 1'b0;
        case (Funct[4:1])
            4'b0100: begin alu_op = ALU_ADD; write_cv = 1'b1; end
            4'b0010: begin alu_op = ALU_SUB; write_cv = 1'b1; end
            4'b0000: alu_op = ALU_AND;
            4'b1100: alu_op = ALU_ORR;
            4'b0001: if (EXT_OPS != 0) alu_op = ALU_EOR; else implemented = 1'b0;
            4'b1101: if (EXT_OPS != 0) alu_op = ALU_MOV; else implemented = 1'b0;
            4'b1000: begin
                if (EXT_OPS != 0) begin
                    alu_op   = ALU_AND;
                    no_write = 1'b1;
                    forced_s = 1'b1;
                end else begin
                    implemented = 1'b0;
                end
            end
            4'b1010: begin
                if (EXT_OPS != 0) begin
                    alu_op   = ALU_SUB;
                    no_write = 1'b1;
                    forced_s = 1'b1;
                    write_cv = 1'b1;
                end else begin
                    implemented = 1'b0;
                end
            end
            default: implemented = 1'b0;
        endcase
        if (!implemented) begin
            alu_op   = ALU_ADD;
            no_write = 1'b1;
            write_cv = 1'b0;
        end
        set_flags = implemented & (Funct[0] | forced_s);
    end

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = Flags;
        case (Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            Flags <= FLAGS_RST;
        end else begin
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    if (!cond_ex) state <= FETCH;
                    else begin
                        case (Op)
                            2'b01:   state <= MEMADR;
                            2'b00:   state <= Funct[5] ? EXECI : EXECR;
                            2'b10:   state <= BRANCH;
                            default: state <= FETCH;
                        endcase
                    end
                end
                MEMADR:   state <= Funct[0] ? MEMREAD : MEMWRITE;
                MEMREAD:  state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: state <= FETCH;
                EXECR, EXECI: begin
                    state <= no_write ? FETCH : ALUWB;
                    if (set_flags) begin
                        Flags[3:2] <= ALUFlags[3:2];
                        if (write_cv) Flags[1:0] <= ALUFlags[1:0];
                    end
                end
                ALUWB:   state <= FETCH;
                BRANCH:  state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        pc_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        case (state)
            FETCH: begin
                ir_w      = 1'b1;
                pc_w      = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMREAD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
                pc_w      = rd_pc;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            EXECR: ALUControl = alu_op;
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_op;
            end
            ALUWB: begin
                reg_w = 1'b1;
                pc_w  = rd_pc;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_w      = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are masked during reset so an abandoned instruction writes nothing
    assign PCWrite  = pc_w  & ~reset;
    assign RegWrite = reg_w & ~reset;
    assign MemWrite = mem_w & ~reset;
    assign IRWrite  = ir_w  & ~reset;
    assign ImmSrc   = Op;
    assign RegSrc   = {Op[0], Op[1]};

endmodule
